ram_arbiter: RTL and testbench

//   Shares the single-port byte-wide parameter/image RAM between NREQ requesters:
//   0 = CNN parameter loader, 1 = image decompressor, 2 = CNN compute engine.

---
 rtl/ram_arbiter_if.sv | 33 +++
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the requesters, the RAM arbiter and the single-port RAM.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the RAM read-data return.
interface ram_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic [ADDR_W-1:0]      ramAddress;
  logic [DATA_W-1:0]      ramDataIn;
  logic [DATA_W-1:0]      ramDataOut;
  logic                   readSignal;
  logic                   writeSignal;
  logic                   busy;

  modport slave (
    input  req, lock, we, addr, wdata, ramDataOut,
    output gnt, rvalid, rdata, ramAddress, ramDataIn, readSignal, writeSignal, busy
  );

  modport master (
    output req, lock, we, addr, wdata, ramDataOut,
    input  gnt, rvalid, rdata, ramAddress, ramDataIn, readSignal, writeSignal, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-wide single-port RAM between NREQ
// requesters. It supports burst locking that is capped at MAX_BURST transfers,
// and it routes read data back to the issuing requester after RD_LAT cycles.
module ram_arbiter #(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         RST,
  ram_arbiter_if.slave bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {ST_ARB, ST_LOCKED} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  owner, owner_next;
  logic [CNT_W-1:0]  burst_cnt, burst_next;
  logic [IDX_W-1:0]  last_gnt;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  logic              xfer;
  logic [NREQ-1:0]   gnt_c;
  logic [NREQ-1:0]   rvalid_c;

  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  logic [ADDR_W-1:0] ram_addr_p0;
  logic [DATA_W-1:0] ram_din_p0;
  logic              wr_p0;
  logic [RD_LAT:0]   rd_vld_p;
  logic [IDX_W-1:0]  rd_id_p [0:RD_LAT];

  // Unpack the per-requester address and write-data lanes.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = bus.addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = bus.wdata[i*DATA_W +: DATA_W];
    end
  end

  // Grant selection (locked owner or round-robin after last_gnt) and lock next-state.
  always_comb begin
    gnt_c      = '0;
    xfer       = 1'b0;
    winner     = '0;
    cand       = '0;
    state_next = ST_ARB;
    owner_next = owner;
    burst_next = burst_cnt;
    if (state == ST_LOCKED) begin
      if (bus.req[owner]) begin
        gnt_c[owner] = 1'b1;
        xfer         = 1'b1;
        winner       = owner;
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDX_W'((int'(last_gnt) + k) % NREQ);
        if (!xfer && bus.req[cand]) begin
          gnt_c[cand] = 1'b1;
          xfer        = 1'b1;
          winner      = cand;
        end
      end
    end
    // Hold the lock only if the owner transferred with lock high and its burst
    // cap is not yet reached. Any other edge drops back to round-robin.
    if (xfer && bus.lock[winner]) begin
      burst_next = (state == ST_LOCKED) ? burst_cnt + CNT_W'(1) : CNT_W'(1);
      if (burst_next < CNT_W'(MAX_BURST)) begin
        state_next = ST_LOCKED;
        owner_next = winner;
      end
    end
  end

  // Lock state, owner, burst length and round-robin pointer.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= ST_ARB;
      owner     <= '0;
      burst_cnt <= '0;
      last_gnt  <= IDX_W'(NREQ - 1);
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      burst_cnt <= burst_next;
      if (xfer) last_gnt <= winner;
    end
  end

  // ---- p0: RAM issue registers; the read-valid shift starts here ----
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ram_addr_p0 <= '0;
      ram_din_p0  <= '0;
      wr_p0       <= 1'b0;
      rd_vld_p    <= '0;
    end else begin
      wr_p0    <= xfer && bus.we[winner];
      rd_vld_p <= {rd_vld_p[RD_LAT-1:0], xfer && !bus.we[winner]};
      if (xfer) begin
        ram_addr_p0 <= addr_a[winner];
        ram_din_p0  <= wdata_a[winner];
      end
    end
  end

  // ---- p1..pRD_LAT: requester id travels alongside its read-valid bit ----
  always_ff @(posedge clk) begin
    rd_id_p[0] <= winner;
    for (int k = 1; k <= RD_LAT; k++) rd_id_p[k] <= rd_id_p[k-1];
  end

  // Steer the read-data-valid pulse to the requester that issued the read.
  always_comb begin
    rvalid_c = '0;
    if (rd_vld_p[RD_LAT]) rvalid_c[rd_id_p[RD_LAT]] = 1'b1;
  end

  assign bus.gnt         = gnt_c;
  assign bus.rvalid      = rvalid_c;
  assign bus.rdata       = bus.ramDataOut;
  assign bus.ramAddress  = ram_addr_p0;
  assign bus.ramDataIn   = ram_din_p0;
  assign bus.readSignal  = rd_vld_p[0];
  assign bus.writeSignal = wr_p0;
  assign bus.busy        = (|rd_vld_p) | (state == ST_LOCKED);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by a randomized run,
// checked against a behavioural arbitration/RAM reference model.
module tb_ram_arbiter;
  localparam int NREQ       = 3;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 2;
  localparam int MAX_BURST  = 16;
  localparam int STARVE_MAX = NREQ * MAX_BURST;

  logic clk = 1'b0;
  logic RST;

  ram_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
                .MAX_BURST(MAX_BURST)) dut (.clk(clk), .RST(RST), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural single-port RAM with RD_LAT read latency (small address window).
  logic [DATA_W-1:0] ram_mem [0:31];
  logic [DATA_W-1:0] ram_q   [0:RD_LAT-1];
  always @(posedge clk) begin
    if (RST) begin
      for (int k = 0; k < 32; k++) ram_mem[k] <= '0;
    end else if (bus.writeSignal) begin
      ram_mem[bus.ramAddress[4:0]] <= bus.ramDataIn;
    end
    ram_q[0] <= bus.readSignal ? ram_mem[bus.ramAddress[4:0]] : DATA_W'($urandom);
    for (int k = 1; k < RD_LAT; k++) ram_q[k] <= ram_q[k-1];
  end
  assign bus.ramDataOut = ram_q[RD_LAT-1];

  // Reference model state.
  typedef struct { int id; logic [DATA_W-1:0] data; int due; } rd_t;
  rd_t               sb[$];
  logic [DATA_W-1:0] ref_mem [0:31];
  int                m_last, m_own, m_cnt;
  logic              exp_rd, exp_wr;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_din;
  int                cyc;
  logic [NREQ-1:0]   obs_gnt, last_xfer;
  int                wait_cnt [NREQ];
  logic              lk [NREQ];
  logic [NREQ-1:0]   win_seq [0:19];
  int                checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = NREQ - 1; m_own = -1; m_cnt = 0;
    sb.delete();
    exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_din = '0;
    last_xfer = '0;
    for (int k = 0; k < 32; k++) ref_mem[k] = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
  endtask

  // Owner (if any) gets exclusive use; otherwise the first requester after the
  // previous winner, going round the ring, wins.
  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] g;
    g = '0;
    if (m_own >= 0) begin
      if (r[m_own]) g[m_own] = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g == '0 && r[(m_last + k) % NREQ]) g[(m_last + k) % NREQ] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic r, input logic l, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req[i]                      = r;
    bus.lock[i]                     = l;
    bus.we[i]                       = w;
    bus.addr[i*ADDR_W +: ADDR_W]    = a;
    bus.wdata[i*DATA_W +: DATA_W]   = d;
  endtask

  // One clock cycle: check everything at the falling edge, advance the model,
  // then return just after the next rising edge.
  task automatic cycle();
    logic [NREQ-1:0]   eg, ev;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                w;
    @(negedge clk);
    cyc++;
    eg = model_gnt(bus.req);
    obs_gnt = bus.gnt;
    chk("gnt", bus.gnt, eg);
    chk("gnt_onehot", ($countones(bus.gnt) <= 1) && ((bus.gnt & ~bus.req) == '0), 1);
    chk("readSignal", bus.readSignal, exp_rd);
    chk("writeSignal", bus.writeSignal, exp_wr);
    if (exp_rd || exp_wr) chk("ramAddress", bus.ramAddress, exp_addr);
    if (exp_wr) chk("ramDataIn", bus.ramDataIn, exp_din);
    chk("busy", bus.busy, (sb.size() > 0) || (m_own >= 0));
    ev = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev[sb[0].id] = 1'b1;
      chk("rdata", bus.rdata, sb[0].data);
      void'(sb.pop_front());
    end
    chk("rvalid", bus.rvalid, ev);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req[i] && bus.gnt[i]) begin
        chk("starvation", wait_cnt[i] <= STARVE_MAX, 1);
        wait_cnt[i] = 0;
      end else if (bus.req[i]) begin
        wait_cnt[i]++;
      end else begin
        wait_cnt[i] = 0;
      end
    end
    last_xfer = bus.req & eg;
    w = -1;
    for (int i = 0; i < NREQ; i++) if (last_xfer[i]) w = i;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (w >= 0) begin
      a = bus.addr[w*ADDR_W +: ADDR_W];
      d = bus.wdata[w*DATA_W +: DATA_W];
      exp_addr = a;
      exp_din  = d;
      if (bus.we[w]) begin
        exp_wr = 1'b1;
        ref_mem[a[4:0]] = d;
      end else begin
        exp_rd = 1'b1;
        sb.push_back('{w, ref_mem[a[4:0]], cyc + 1 + RD_LAT});
      end
      m_last = w;
      if (bus.lock[w]) begin
        m_cnt = (m_own >= 0) ? m_cnt + 1 : 1;
        m_own = (m_cnt >= MAX_BURST) ? -1 : w;
      end else begin
        m_own = -1;
      end
    end else begin
      m_own = -1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n1;
    logic [NREQ-1:0] t1_exp [0:3];
    t1_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    checks = 0; errors = 0; cyc = 0;
    bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < NREQ; i++) lk[i] = 1'b0;
    RST = 1'b1;
    model_reset();

    // Reset state, and the combinational grant while held in reset.
    #7;
    chk("rst readSignal", bus.readSignal, 0);
    chk("rst writeSignal", bus.writeSignal, 0);
    chk("rst ramAddress", bus.ramAddress, 0);
    chk("rst ramDataIn", bus.ramDataIn, 0);
    chk("rst rvalid", bus.rvalid, 0);
    chk("rst busy", bus.busy, 0);
    bus.req = 3'b111;
    #1;
    chk("rst gnt", bus.gnt, 3'b001);
    bus.req = '0;
    @(negedge clk); @(negedge clk);
    RST = 1'b0;
    @(posedge clk); #1;

    // Round-robin order with all three requesters reading.
    set_req(0, 1, 0, 0, 16'd1, 8'h00);
    set_req(1, 1, 0, 0, 16'd2, 8'h00);
    set_req(2, 1, 0, 0, 16'd3, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t1 order", obs_gnt, t1_exp[k]);
    end
    bus.req = '0;
    repeat (RD_LAT + 2) cycle();

    // Write then read of the same address returns the new data.
    set_req(0, 1, 0, 1, 16'd5, 8'hA5);
    cycle();
    chk("t2 write gnt", obs_gnt, 3'b001);
    set_req(0, 1, 0, 0, 16'd5, 8'h00);
    cycle();
    chk("t2 read gnt", obs_gnt, 3'b001);
    bus.req = '0;
    chk("t2 readSignal", bus.readSignal, 1);
    repeat (RD_LAT) cycle();
    chk("t2 rvalid", bus.rvalid, 3'b001);
    chk("t2 rdata", bus.rdata, 8'hA5);
    repeat (2) cycle();

    // Locked burst from requester 1 is capped at MAX_BURST.
    set_req(0, 1, 0, 0, 16'd7, 8'h00);
    set_req(1, 1, 1, 0, 16'd8, 8'h00);
    set_req(2, 1, 0, 0, 16'd9, 8'h00);
    for (int k = 0; k < 20; k++) begin
      cycle();
      win_seq[k] = obs_gnt;
    end
    n1 = 0;
    for (int k = 0; k < 16; k++) if (win_seq[k] == 3'b010) n1++;
    chk("t3 burst len", n1, 16);
    chk("t3 after burst", win_seq[16], 3'b100);
    chk("t3 next rr", win_seq[17], 3'b001);
    chk("t3 relock", win_seq[18], 3'b010);
    bus.req = '0; bus.lock = '0;
    repeat (RD_LAT + 3) cycle();

    // Owner drops its request mid-burst: one idle edge, then the waiter wins.
    set_req(0, 1, 0, 0, 16'd10, 8'h00);
    set_req(2, 1, 1, 0, 16'd11, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4 locked gnt", obs_gnt, 3'b100);
    end
    bus.req[2] = 1'b0;
    cycle();
    chk("t4 release gnt", obs_gnt, 3'b000);
    cycle();
    chk("t4 waiter gnt", obs_gnt, 3'b001);
    bus.req = '0; bus.lock = '0;
    repeat (RD_LAT + 3) cycle();

    // Asynchronous reset with a read in flight and the lock held.
    set_req(1, 1, 1, 0, 16'd12, 8'h00);
    cycle();
    cycle();
    chk("t5 busy before", bus.busy, 1);
    #1 RST = 1'b1;
    #1;
    chk("t5 readSignal", bus.readSignal, 0);
    chk("t5 writeSignal", bus.writeSignal, 0);
    chk("t5 rvalid", bus.rvalid, 0);
    chk("t5 busy", bus.busy, 0);
    chk("t5 ramAddress", bus.ramAddress, 0);
    bus.req = 3'b111;
    #1;
    chk("t5 rst gnt", bus.gnt, 3'b001);
    bus.req = '0; bus.lock = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    RST = 1'b0;
    @(posedge clk); #1;
    repeat (RD_LAT + 4) cycle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] || last_xfer[i]) begin
          if ($urandom_range(0, 19) == 0) lk[i] = ~lk[i];
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1, lk[i], 1'($urandom_range(0, 1)),
                    ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
          else
            bus.req[i] = 1'b0;
        end
      end
      cycle();
    end
    bus.req = '0; bus.lock = '0;
    repeat (RD_LAT + 3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
